mem_access_queue: RTL and testbench
===================================

Name: mem_access_queue

Overview:
- Parametrised, multi-outstanding successor to the Execute stage's single-request data_sram handshake.
- Accepts load/store ops from Execute and issues them in order on the req/addr_ok/data_ok data-SRAM bus, keeping up to DEPTH ops in flight.
- Returns formatted (sign/zero-extended) load data or store completion to Memory stage, in program order, with a tag.
- Drops in-flight responses on pipeline flush (ex_en).

Parameters:
- DEPTH, 4: queue entries (power of 2, >=2); max ops allocated (issuing + outstanding + awaiting pop).
- TAG_W, 5: width of op tag (destination register index).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush (ex_en)
- in_valid  in  1  op offered
- in_ready  out  1  op accepted when in_valid&&in_ready
- in_wr  in  1  1=store, 0=load
- in_size  in  2  0=byte, 1=half, 2=word
- in_wstrb  in  4  store byte strobes
- in_addr  in  32  physical address
- in_wdata  in  32  store data, pre-replicated
- in_ld_signed  in  1  sign-extend load
- in_tag  in  TAG_W  op tag
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  write
- data_sram_size  out  2  size
- data_sram_wstrb  out  4  strobes
- data_sram_addr  out  32  address
- data_sram_wdata  out  32  write data
- data_sram_addr_ok  in  1  address accepted
- data_sram_data_ok  in  1  data returned / write done
- data_sram_rdata  in  32  read data
- rsp_valid  out  1  response available
- rsp_ready  in  1  Memory stage takes response
- rsp_wr  out  1  response is for a store
- rsp_tag  out  TAG_W  tag of response
- rsp_data  out  32  extended load data; 0 for stores
- perf_req_cnt  out  32  issued-request counter (optional feature)
- perf_stall_cnt  out  32  req-without-addr_ok cycle counter (optional feature)

Behaviour:
- Circular entry array; pointers head (pop), cmpl (next data_ok), issue (next bus req), tail (alloc), each log2(DEPTH)+1 bits. Invariant: head<=cmpl<=issue<=tail modulo wrap.
- live = tail-head. Full when live==DEPTH; empty when 0.
- in_ready = (live<DEPTH) && !flush. Accepted op written at tail; tail++.
- Entry fields: wr, size, wstrb, addr, wdata, ld_signed, tag, drop, done, rdata.
- data_sram_req = (issue!=tail). Bus fields driven combinationally from entry[issue]. On req&&addr_ok, issue++.
- Once req is high, req and its fields stay stable until addr_ok, flush included.
- Earliest issue: cycle after acceptance.
- data_sram_data_ok (when cmpl!=issue): entry[cmpl].rdata <= rdata, done <= 1, cmpl++.
- data_ok with cmpl==issue is ignored (protocol error).
- Load extract: shift rdata right by 8*addr[1:0]. Byte -> bits[7:0], half -> bits[15:0], each extended by ld_signed; word unchanged.
- rsp_valid = entry[head].done && !entry[head].drop. rsp_* fields come from entry[head].
- Latency: data_ok in cycle N gives rsp_valid in cycle N+1 at the earliest.
- Pop occurs on rsp_valid&&rsp_ready, or automatically when entry[head] is done and dropped. head++.
- Flush cycle:
  - Every entry in [head, tail) is marked drop.
  - If req is high this cycle: tail <= issue+1 (current request kept, completes silently).
  - Else: tail <= issue (unissued entries freed).
  - Same-cycle accept is impossible (in_ready=0). rsp_valid is 0 from the next cycle.
- Simultaneous accept, issue, data_ok and pop in one cycle are all legal. live updates by +accept-pop.
- Reset:
  - All pointers and entry done/drop flags cleared; data_sram_req=0, in_ready=1, rsp_valid=0.
  - All output data fields are 0 while the queue is empty.
  - Reset mid-transaction abandons outstanding bus ops; the bus is reset with the core.

Optional Feature:
- MAQ_PERF_EN defined:
  - perf_req_cnt increments on each req&&addr_ok.
  - perf_stall_cnt increments each cycle with req&&!addr_ok.
  - Both 32-bit, wrap at 2^32, cleared by reset, unaffected by flush.
- Not defined: both ports are tied to 0 and no counter logic exists.

Test Plan:
- Single load: in_addr=0x1002, size=1, signed=1, tag=7; addr_ok next cycle; data_ok with rdata=0x80FF1234 two cycles later -> rsp_valid one cycle later, rsp_tag=7, rsp_data=0xFFFF80FF.
- Fill: DEPTH=4, 4 loads accepted, addr_ok held 0 -> in_ready=0 after 4th accept; req stable on entry 0; perf_stall_cnt counts held cycles (MAQ_PERF_EN).
- Pipelined: 3 loads, addr_ok every cycle, data_ok for rdata 0x11,0x22,0x33 -> responses in order, tags preserved, no bubbles with rsp_ready=1.
- Backpressure: rsp_ready=0 while 4 ops complete -> in_ready=0 at live=4; raising rsp_ready pops one per cycle.
- Flush: 2 issued + 1 requesting (no addr_ok) + 1 unissued, flush=1 -> tail=issue+1; requesting entry issues after flush; 3 data_ok arrive, rsp_valid never asserts; live returns to 0.
- Byte store: wr=1, addr=0x2003, wstrb=4'b1000, wdata=0xABABABAB -> bus fields exact; data_ok -> rsp_wr=1, rsp_data=0.

Source files
------------

// File: rtl/mem_access_queue.sv
// In-order, multi-outstanding load/store queue between Execute and the
// data-SRAM req/addr_ok/data_ok bus. Up to DEPTH ops are allocated at once;
// responses go back to Memory stage in program order with their tag.
// Optional feature: define MAQ_PERF_EN to build the perf counters.
module mem_access_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wr,
  input  logic [1:0]       in_size,
  input  logic [3:0]       in_wstrb,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  input  logic             in_ld_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             data_sram_req,
  output logic             data_sram_wr,
  output logic [1:0]       data_sram_size,
  output logic [3:0]       data_sram_wstrb,
  output logic [31:0]      data_sram_addr,
  output logic [31:0]      data_sram_wdata,
  input  logic             data_sram_addr_ok,
  input  logic             data_sram_data_ok,
  input  logic [31:0]      data_sram_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  output logic [31:0]      perf_req_cnt,
  output logic [31:0]      perf_stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic             wr;
    logic [1:0]       size;
    logic [3:0]       wstrb;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             ld_signed;
    logic [TAG_W-1:0] tag;
    logic             drop;
    logic             done;
    logic [31:0]      rdata;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d, cmpl_q, cmpl_d, issue_q, issue_d, tail_q, tail_d;
  logic [PW-1:0] live;
  logic [AW-1:0] head_i, cmpl_i, issue_i, tail_i;
  logic          req, accept, issue_go, cmpl_go, pop, hd_done;
  logic [15:0]   ld_sh;
  logic [31:0]   ld_ext;

  assign head_i  = head_q[AW-1:0];
  assign cmpl_i  = cmpl_q[AW-1:0];
  assign issue_i = issue_q[AW-1:0];
  assign tail_i  = tail_q[AW-1:0];

  assign live     = tail_q - head_q;
  assign in_ready = (live < PW'(DEPTH)) && !flush;
  assign accept   = in_valid && in_ready;

  // The bus request is whatever sits at issue; fields hold until addr_ok
  // because flush never moves tail below issue+1 while req is up.
  assign req      = (issue_q != tail_q);
  assign issue_go = req && data_sram_addr_ok;
  // data_ok with nothing outstanding is a protocol error and is ignored.
  assign cmpl_go  = data_sram_data_ok && (cmpl_q != issue_q);

  assign data_sram_req   = req;
  assign data_sram_wr    = req && ent_q[issue_i].wr;
  assign data_sram_size  = req ? ent_q[issue_i].size  : 2'b00;
  assign data_sram_wstrb = req ? ent_q[issue_i].wstrb : 4'h0;
  assign data_sram_addr  = req ? ent_q[issue_i].addr  : 32'h0;
  assign data_sram_wdata = req ? ent_q[issue_i].wdata : 32'h0;

  // Dropped entries retire on their own once their bus op completes.
  assign hd_done   = (live != '0) && ent_q[head_i].done;
  assign rsp_valid = hd_done && !ent_q[head_i].drop;
  assign pop       = hd_done && (ent_q[head_i].drop || rsp_ready);

  assign ld_sh = 16'(ent_q[head_i].rdata >> {ent_q[head_i].addr[1:0], 3'b000});

  // Align and extend load data of the head entry
  always_comb begin
    case (ent_q[head_i].size)
      2'd0:    ld_ext = {{24{ent_q[head_i].ld_signed & ld_sh[7]}}, ld_sh[7:0]};
      2'd1:    ld_ext = {{16{ent_q[head_i].ld_signed & ld_sh[15]}}, ld_sh};
      default: ld_ext = ent_q[head_i].rdata;
    endcase
  end

  assign rsp_wr   = rsp_valid && ent_q[head_i].wr;
  assign rsp_tag  = rsp_valid ? ent_q[head_i].tag : '0;
  assign rsp_data = (rsp_valid && !ent_q[head_i].wr) ? ld_ext : 32'h0;

  // Next state: allocate at tail, issue, complete at cmpl, pop at head, flush
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    cmpl_d  = cmpl_q;
    issue_d = issue_q;
    tail_d  = tail_q;
    if (accept) begin
      ent_d[tail_i] = '{wr: in_wr, size: in_size, wstrb: in_wstrb, addr: in_addr,
                        wdata: in_wdata, ld_signed: in_ld_signed, tag: in_tag,
                        drop: 1'b0, done: 1'b0, rdata: 32'h0};
      tail_d = tail_q + PW'(1);
    end
    if (issue_go) issue_d = issue_q + PW'(1);
    if (cmpl_go) begin
      ent_d[cmpl_i].rdata = data_sram_rdata;
      ent_d[cmpl_i].done  = 1'b1;
      cmpl_d = cmpl_q + PW'(1);
    end
    if (pop) begin
      ent_d[head_i].done = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++)
        if (PW'(k) < live) ent_d[AW'(head_i + AW'(k))].drop = 1'b1;
      // a request already on the bus must finish; everything behind it is freed
      tail_d = req ? issue_q + PW'(1) : issue_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      cmpl_q  <= '0;
      issue_q <= '0;
      tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      cmpl_q  <= cmpl_d;
      issue_q <= issue_d;
      tail_q  <= tail_d;
      ent_q   <= ent_d;
    end
  end

`ifdef MAQ_PERF_EN
  logic [31:0] perf_req_q, perf_req_d, perf_stall_q, perf_stall_d;

  // Count accepted bus requests and cycles a request waits for addr_ok
  always_comb begin
    perf_req_d   = perf_req_q + {31'd0, issue_go};
    perf_stall_d = perf_stall_q + {31'd0, req && !data_sram_addr_ok};
  end

  // Perf counter registers; flush does not touch them
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_req_q   <= perf_req_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_req_cnt   = perf_req_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_req_cnt   = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_queue.sv
// Bench for mem_access_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-level reference model.
module tb_mem_access_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, in_ready, in_wr, in_ld_signed;
  logic [1:0]       in_size;
  logic [3:0]       in_wstrb;
  logic [31:0]      in_addr, in_wdata;
  logic [TAG_W-1:0] in_tag;
  logic             data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]       data_sram_size;
  logic [3:0]       data_sram_wstrb;
  logic [31:0]      data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic             rsp_valid, rsp_ready, rsp_wr;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data, perf_req_cnt, perf_stall_cnt;

  always #5 clk = ~clk;

  mem_access_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr), .in_size(in_size),
    .in_wstrb(in_wstrb), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_ld_signed(in_ld_signed), .in_tag(in_tag),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  // Reference model: program-ordered list of allocated ops. The first n_iss
  // have been accepted by the bus, the first n_cmpl have their data back.
  typedef struct {
    logic             wr;
    logic [1:0]       size;
    logic [3:0]       wstrb;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             sg;
    logic [TAG_W-1:0] tag;
    bit               drop;
    logic [31:0]      rdata;
  } mop_t;

  mop_t mq[$];
  int   n_iss, n_cmpl;
  int   n_vec, n_err;
`ifdef MAQ_PERF_EN
  logic [31:0] m_preq, m_pstall;
`endif

  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tg, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_val(input mop_t m);
    logic [31:0] s;
    s = m.rdata >> (8 * m.addr[1:0]);
    case (m.size)
      2'd0:    return (s & 32'hFF)   | ((m.sg && s[7])  ? 32'hFFFFFF00 : 32'h0);
      2'd1:    return (s & 32'hFFFF) | ((m.sg && s[15]) ? 32'hFFFF0000 : 32'h0);
      default: return m.rdata;
    endcase
  endfunction

  // One clock: check outputs at negedge against the model, then advance it.
  task automatic step();
    int   sz, keep;
    bit   e_rdy, e_req, e_rv, acc, iss, dok, pop;
    mop_t m;
    @(negedge clk);
    sz    = mq.size();
    e_rdy = (sz < DEPTH) && !flush;
    e_req = (n_iss < sz);
    e_rv  = (n_cmpl > 0) && !mq[0].drop;
    if (rstn) begin
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("bus_req", 32'(data_sram_req), 32'(e_req));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_req) begin
        chk("bus_wr", 32'(data_sram_wr), 32'(mq[n_iss].wr));
        chk("bus_size", 32'(data_sram_size), 32'(mq[n_iss].size));
        chk("bus_wstrb", 32'(data_sram_wstrb), 32'(mq[n_iss].wstrb));
        chk("bus_addr", data_sram_addr, mq[n_iss].addr);
        chk("bus_wdata", data_sram_wdata, mq[n_iss].wdata);
      end
      if (e_rv) begin
        chk("rsp_wr", 32'(rsp_wr), 32'(mq[0].wr));
        chk("rsp_tag", 32'(rsp_tag), 32'(mq[0].tag));
        chk("rsp_data", rsp_data, mq[0].wr ? 32'h0 : ld_val(mq[0]));
      end
      if (sz == 0) begin
        chk("idle_addr", data_sram_addr, 32'h0);
        chk("idle_wdata", data_sram_wdata, 32'h0);
        chk("idle_rsp_data", rsp_data, 32'h0);
        chk("idle_rsp_tag", 32'(rsp_tag), 32'h0);
      end
`ifdef MAQ_PERF_EN
      chk("perf_req", perf_req_cnt, m_preq);
      chk("perf_stall", perf_stall_cnt, m_pstall);
`else
      chk("perf_req", perf_req_cnt, 32'h0);
      chk("perf_stall", perf_stall_cnt, 32'h0);
`endif
    end
    if (!rstn) begin
      mq.delete();
      n_iss  = 0;
      n_cmpl = 0;
`ifdef MAQ_PERF_EN
      m_preq   = 0;
      m_pstall = 0;
`endif
    end else begin
      acc = in_valid && e_rdy;
      iss = e_req && data_sram_addr_ok;
      dok = data_sram_data_ok && (n_cmpl < n_iss);
      pop = (n_cmpl > 0) && (mq[0].drop || rsp_ready);
`ifdef MAQ_PERF_EN
      if (iss) m_preq++;
      if (e_req && !data_sram_addr_ok) m_pstall++;
`endif
      if (dok) begin
        m = mq[n_cmpl];
        m.rdata = data_sram_rdata;
        mq[n_cmpl] = m;
      end
      if (flush) begin
        for (int i = 0; i < mq.size(); i++) begin
          m = mq[i];
          m.drop = 1'b1;
          mq[i] = m;
        end
        keep = n_iss + int'(e_req);
        while (mq.size() > keep) void'(mq.pop_back());
      end
      if (iss) n_iss++;
      if (dok) n_cmpl++;
      if (acc) begin
        m = '{in_wr, in_size, in_wstrb, in_addr, in_wdata, in_ld_signed, in_tag, 1'b0, 32'h0};
        mq.push_back(m);
      end
      if (pop) begin
        void'(mq.pop_front());
        n_iss--;
        n_cmpl--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; in_wr = 1'b0; in_size = 2'd0;
    in_wstrb = 4'h0; in_addr = 32'h0; in_wdata = 32'h0; in_ld_signed = 1'b0;
    in_tag = '0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0; rsp_ready = 1'b0;
  endtask

  task automatic set_op(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                        input logic [31:0] a, input logic [31:0] wd, input logic sg,
                        input logic [TAG_W-1:0] tg);
    in_valid = 1'b1; in_wr = wr; in_size = sz; in_wstrb = st;
    in_addr = a; in_wdata = wd; in_ld_signed = sg; in_tag = tg;
  endtask

  // Bus slave always answers; bounded so a stuck DUT still reaches the summary.
  task automatic drain();
    int cnt;
    cnt = 0;
    in_valid = 1'b0; flush = 1'b0; rstn = 1'b1; data_sram_addr_ok = 1'b1; rsp_ready = 1'b1;
    while (mq.size() != 0 && cnt < 64) begin
      data_sram_data_ok = (n_cmpl < n_iss);
      data_sram_rdata = $urandom;
      step();
      cnt++;
    end
    data_sram_data_ok = 1'b0;
    data_sram_addr_ok = 1'b0;
    chk("drain_req", 32'(data_sram_req), 32'h0);
    chk("drain_rdy", 32'(in_ready), 32'h1);
  endtask

  task automatic rnd_cycle();
    in_valid     = 1'($urandom_range(0, 1));
    in_wr        = 1'($urandom_range(0, 1));
    in_size      = 2'($urandom_range(0, 2));
    in_wstrb     = 4'($urandom);
    in_addr      = $urandom;
    in_wdata     = $urandom;
    in_ld_signed = 1'($urandom_range(0, 1));
    in_tag       = TAG_W'($urandom);
    data_sram_addr_ok = ($urandom_range(0, 9) < 6);
    data_sram_data_ok = (n_cmpl < n_iss) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
    data_sram_rdata   = $urandom;
    rsp_ready = ($urandom_range(0, 9) < 7);
    flush     = ($urandom_range(0, 39) == 0);
    rstn      = ($urandom_range(0, 299) != 0);
    step();
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_iss = 0; n_cmpl = 0;
    idle();
    rstn = 1'b0;
    @(posedge clk); #1;
    step(); step();
    rstn = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_req", 32'(data_sram_req), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);

    // single signed half load
    set_op(1'b0, 2'd1, 4'h0, 32'h1002, 32'h0, 1'b1, TAG_W'(7)); step();
    in_valid = 1'b0; data_sram_addr_ok = 1'b1;
    chk("ld_req", 32'(data_sram_req), 32'h1);
    step();
    data_sram_addr_ok = 1'b0; step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF1234; step();
    data_sram_data_ok = 1'b0;
    chk("ld_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("ld_rsp_tag", 32'(rsp_tag), 32'd7);
    chk("ld_rsp_data", rsp_data, 32'hFFFF80FF);
    rsp_ready = 1'b1; step();
    rsp_ready = 1'b0;

    // fill with addr_ok held low
    for (int i = 0; i < 4; i++) begin
      set_op(1'b0, 2'd2, 4'h0, 32'(32'h100 + 4 * i), 32'h0, 1'b0, TAG_W'(i)); step();
    end
    in_valid = 1'b0;
    chk("fill_rdy", 32'(in_ready), 32'h0);
    chk("fill_addr", data_sram_addr, 32'h100);
    step(); step(); step();
    chk("fill_addr_held", data_sram_addr, 32'h100);
    drain();

    // pipelined word loads
    rsp_ready = 1'b1;
    set_op(1'b0, 2'd2, 4'h0, 32'h200, 32'h0, 1'b0, TAG_W'(10)); step();
    set_op(1'b0, 2'd2, 4'h0, 32'h204, 32'h0, 1'b0, TAG_W'(11)); data_sram_addr_ok = 1'b1; step();
    set_op(1'b0, 2'd2, 4'h0, 32'h208, 32'h0, 1'b0, TAG_W'(12));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11; step();
    in_valid = 1'b0; data_sram_rdata = 32'h22;
    chk("pipe_d0", rsp_data, 32'h11); chk("pipe_t0", 32'(rsp_tag), 32'd10); step();
    data_sram_addr_ok = 1'b0; data_sram_rdata = 32'h33;
    chk("pipe_d1", rsp_data, 32'h22); chk("pipe_t1", 32'(rsp_tag), 32'd11); step();
    data_sram_data_ok = 1'b0;
    chk("pipe_d2", rsp_data, 32'h33); chk("pipe_t2", 32'(rsp_tag), 32'd12); step();
    chk("pipe_empty", 32'(rsp_valid), 32'h0);

    // response backpressure
    rsp_ready = 1'b0; data_sram_addr_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) set_op(1'b0, 2'd0, 4'h0, 32'(32'h300 + i), 32'h0, 1'($urandom_range(0, 1)), TAG_W'(20 + i));
      else in_valid = 1'b0;
      data_sram_data_ok = (n_cmpl < n_iss); data_sram_rdata = $urandom;
      step();
    end
    data_sram_data_ok = 1'b0; data_sram_addr_ok = 1'b0;
    chk("bp_rdy", 32'(in_ready), 32'h0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_pop_rv", 32'(rsp_valid), 32'h1);
      step();
    end
    chk("bp_empty_rv", 32'(rsp_valid), 32'h0);

    // flush with 2 issued, 1 requesting, 1 unissued
    set_op(1'b0, 2'd2, 4'h0, 32'h400, 32'h0, 1'b0, TAG_W'(1)); step();
    set_op(1'b0, 2'd2, 4'h0, 32'h404, 32'h0, 1'b0, TAG_W'(2)); data_sram_addr_ok = 1'b1; step();
    set_op(1'b0, 2'd2, 4'h0, 32'h408, 32'h0, 1'b0, TAG_W'(3)); step();
    set_op(1'b0, 2'd2, 4'h0, 32'h40C, 32'h0, 1'b0, TAG_W'(4)); data_sram_addr_ok = 1'b0; step();
    in_valid = 1'b0; flush = 1'b1;
    chk("fl_rdy", 32'(in_ready), 32'h0);
    step();
    flush = 1'b0;
    chk("fl_req_held", 32'(data_sram_req), 32'h1);
    chk("fl_addr_held", data_sram_addr, 32'h408);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5A5A5A5A; step();
    data_sram_addr_ok = 1'b0; step();
    chk("fl_no_rsp", 32'(rsp_valid), 32'h0);
    step();
    data_sram_data_ok = 1'b0; step();
    chk("fl_idle_req", 32'(data_sram_req), 32'h0);
    chk("fl_idle_rv", 32'(rsp_valid), 32'h0);
    chk("fl_idle_rdy", 32'(in_ready), 32'h1);

    // byte store
    set_op(1'b1, 2'd0, 4'b1000, 32'h2003, 32'hABABABAB, 1'b0, TAG_W'(9)); step();
    in_valid = 1'b0;
    chk("st_wr", 32'(data_sram_wr), 32'h1);
    chk("st_size", 32'(data_sram_size), 32'h0);
    chk("st_wstrb", 32'(data_sram_wstrb), 32'h8);
    chk("st_addr", data_sram_addr, 32'h2003);
    chk("st_wdata", data_sram_wdata, 32'hABABABAB);
    data_sram_addr_ok = 1'b1; step();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF; step();
    data_sram_data_ok = 1'b0;
    chk("st_rsp_wr", 32'(rsp_wr), 32'h1);
    chk("st_rsp_data", rsp_data, 32'h0);
    chk("st_rsp_tag", 32'(rsp_tag), 32'd9);
    step();

    // randomized traffic
    repeat (3000) rnd_cycle();
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
